reg_to_apb_master: RTL and testbench

Bridge from a REG_BUS slave port to an APB3 master port. It is the initiator-side counterpart of apb_to_reg. It lets register-bus masters, such as the padframe or hyperbus configuration fabrics, drive legacy APB peripherals. It sequences a compliant APB SETUP/ACCESS transfer, guards the transfer with a pready timeout, and reports completion and errors back on REG_BUS.

---
 rtl/reg_to_apb_master.sv | 113 +++++++++++
 tb/tb_reg_to_apb_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_apb_master.sv
// REG_BUS slave to APB3 master bridge: one SETUP/ACCESS transfer per request,
// with an optional pready timeout and registered completion back on REG_BUS.
module reg_to_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   reg_addr_i,
    input  logic                    reg_write_i,
    input  logic [DATA_WIDTH-1:0]   reg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] reg_wstrb_i,
    input  logic                    reg_valid_i,
    output logic [DATA_WIDTH-1:0]   reg_rdata_o,
    output logic                    reg_error_o,
    output logic                    reg_ready_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic                    pwrite_o,
    output logic                    psel_o,
    output logic                    penable_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i,
    output logic                    timeout_o
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             full_strb;

    // APB has no byte strobes, so partial writes cannot be forwarded.
    assign full_strb = &reg_wstrb_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            reg_rdata_o <= '0;
            reg_error_o <= 1'b0;
            reg_ready_o <= 1'b0;
            paddr_o     <= '0;
            pwdata_o    <= '0;
            pwrite_o    <= 1'b0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    reg_ready_o <= 1'b0;
                    timeout_o   <= 1'b0;
                    if (reg_valid_i) begin
                        if (!reg_write_i || full_strb) begin
                            paddr_o  <= reg_addr_i;
                            pwdata_o <= reg_wdata_i;
                            pwrite_o <= reg_write_i;
                            psel_o   <= 1'b1;
                            state    <= SETUP;
                        end else begin
                            reg_ready_o <= 1'b1;
                            reg_error_o <= 1'b1;
                            reg_rdata_o <= '0;
                            state       <= RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        reg_ready_o <= 1'b1;
                        reg_rdata_o <= pwrite_o ? '0 : prdata_i;
                        reg_error_o <= pslverr_i;
                        state       <= RESP;
                    end else if (TIMEOUT_CYCLES != 0 && wait_cnt == CNT_LAST) begin
                        psel_o      <= 1'b0;
                        penable_o   <= 1'b0;
                        reg_ready_o <= 1'b1;
                        reg_rdata_o <= '0;
                        reg_error_o <= 1'b1;
                        timeout_o   <= 1'b1;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    reg_ready_o <= 1'b0;
                    reg_error_o <= 1'b0;
                    reg_rdata_o <= '0;
                    timeout_o   <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_to_apb_master.sv
// Self-checking bench: each transfer's per-cycle output trace is derived from
// the request parameters and queued; a negedge process compares it to the DUT.
module tb_reg_to_apb_master;

    localparam int TMO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] reg_addr_i;
    logic        reg_write_i;
    logic [31:0] reg_wdata_i;
    logic [3:0]  reg_wstrb_i;
    logic        reg_valid_i;
    logic [31:0] reg_rdata_o;
    logic        reg_error_o;
    logic        reg_ready_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic        pwrite_o;
    logic        psel_o;
    logic        penable_o;
    logic [31:0] prdata_i;
    logic        pready_i;
    logic        pslverr_i;
    logic        timeout_o;

    reg_to_apb_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .reg_addr_i(reg_addr_i), .reg_write_i(reg_write_i),
        .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
        .reg_valid_i(reg_valid_i), .reg_rdata_o(reg_rdata_o),
        .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pwrite_o(pwrite_o),
        .psel_o(psel_o), .penable_o(penable_o),
        .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        psel;
        logic        pen;
        logic        rdy;
        logic        tout;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic        chk_bus;
        logic        chk_all;
    } exp_t;

    exp_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rdy_cyc = -1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    logic        last_tout = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    // Compare the queued expectation for this cycle against the DUT outputs.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_output("psel", 32'(psel_o), 32'(e.psel));
            check_output("penable", 32'(penable_o), 32'(e.pen));
            check_output("ready", 32'(reg_ready_o), 32'(e.rdy));
            check_output("timeout", 32'(timeout_o), 32'(e.tout));
            if (e.chk_bus || e.chk_all) begin
                check_output("paddr", paddr_o, e.addr);
                check_output("pwdata", pwdata_o, e.wdata);
                check_output("pwrite", 32'(pwrite_o), 32'(e.write));
            end
            if (e.rdy || e.chk_all) begin
                check_output("rdata", reg_rdata_o, e.rdata);
                check_output("error", 32'(reg_error_o), 32'(e.err));
            end
            if (reg_ready_o === 1'b1) begin
                rdy_cyc    = cyc;
                last_rdata = reg_rdata_o;
                last_err   = reg_error_o;
                last_tout  = timeout_o;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        exp_t e;
        repeat (n) begin
            reg_valid_i = 1'b0;
            reg_addr_i  = $urandom;
            pready_i    = 1'($urandom);
            prdata_i    = $urandom;
            pslverr_i   = 1'($urandom);
            e = '0;
            exp_q.push_back(e);
            tick();
        end
    endtask

    // One REG_BUS request; dly = pready wait cycles in ACCESS.
    task automatic apply_stimulus(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                  input logic [3:0] ws, input int dly, input logic serr,
                                  input logic [31:0] rd);
        exp_t e;
        int   k;
        logic done;
        logic tmo;
        reg_valid_i = 1'b1;
        reg_addr_i  = a;
        reg_write_i = w;
        reg_wdata_i = wd;
        reg_wstrb_i = ws;
        pready_i    = 1'b0;
        prdata_i    = $urandom;
        pslverr_i   = 1'($urandom);
        e = '0;
        exp_q.push_back(e);
        tick();
        if (w && ws != 4'hF) begin
            e = '0;
            e.rdy = 1'b1;
            e.err = 1'b1;
            exp_q.push_back(e);
            tick();
        end else begin
            e = '0;
            e.psel = 1'b1;
            e.addr = a;
            e.wdata = wd;
            e.write = w;
            e.chk_bus = 1'b1;
            exp_q.push_back(e);
            prdata_i  = $urandom;
            pslverr_i = 1'($urandom);
            tick();
            done = 1'b0;
            tmo  = 1'b0;
            k    = 0;
            e.pen = 1'b1;
            while (!done) begin
                exp_q.push_back(e);
                if (k == dly) begin
                    pready_i  = 1'b1;
                    prdata_i  = rd;
                    pslverr_i = serr;
                    done      = 1'b1;
                end else begin
                    pready_i  = 1'b0;
                    prdata_i  = $urandom;
                    pslverr_i = 1'($urandom);
                    if (k == TMO - 1) begin
                        done = 1'b1;
                        tmo  = 1'b1;
                    end
                end
                tick();
                k++;
            end
            e = '0;
            e.rdy   = 1'b1;
            e.tout  = tmo;
            e.err   = tmo ? 1'b1 : serr;
            e.rdata = (tmo || w) ? 32'h0 : rd;
            exp_q.push_back(e);
            pready_i = 1'b0;
            prdata_i = $urandom;
            tick();
        end
        reg_valid_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   start;
        logic [3:0] ws;
        rst_ni = 1'b0;
        reg_valid_i = 1'b0; reg_addr_i = '0; reg_write_i = 1'b0;
        reg_wdata_i = '0; reg_wstrb_i = '0;
        prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
        tick();
        e = '0;
        e.chk_all = 1'b1;
        exp_q.push_back(e);
        rst_ni = 1'b1;
        tick();
        idle(2);

        start = cyc;
        apply_stimulus(32'h1A10_4000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE_F00D);
        check_output("t1_latency", 32'(rdy_cyc - start), 32'd3);
        check_output("t1_rdata", last_rdata, 32'hCAFE_F00D);
        check_output("t1_error", 32'(last_err), 32'd0);

        start = cyc;
        apply_stimulus(32'h1A10_5004, 1'b1, 32'h0000_00FF, 4'hF, 3, 1'b0, 32'h1234_5678);
        check_output("t2_latency", 32'(rdy_cyc - start), 32'd6);
        check_output("t2_rdata", last_rdata, 32'd0);

        start = cyc;
        apply_stimulus(32'h1A10_5008, 1'b1, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 32'h0);
        check_output("t3_latency", 32'(rdy_cyc - start), 32'd1);
        check_output("t3_error", 32'(last_err), 32'd1);

        apply_stimulus(32'h1A10_600C, 1'b0, 32'h0, 4'hF, 0, 1'b1, 32'h5555_AAAA);
        check_output("t4_error", 32'(last_err), 32'd1);
        check_output("t4_timeout", 32'(last_tout), 32'd0);

        start = cyc;
        apply_stimulus(32'h1A10_7000, 1'b0, 32'h0, 4'hF, 100, 1'b0, 32'h0);
        check_output("t5_latency", 32'(rdy_cyc - start), 32'd10);
        check_output("t5_timeout", 32'(last_tout), 32'd1);
        apply_stimulus(32'h1A10_7004, 1'b0, 32'h0, 4'hF, TMO - 1, 1'b0, 32'h0BAD_CAFE);
        check_output("t5_next_rdata", last_rdata, 32'h0BAD_CAFE);
        idle(1);

        // Reset in the second ACCESS cycle of a long read.
        reg_valid_i = 1'b1; reg_addr_i = 32'h1A10_8000; reg_write_i = 1'b0;
        reg_wstrb_i = 4'hF; pready_i = 1'b0;
        e = '0;
        exp_q.push_back(e);
        tick();
        e = '0; e.psel = 1'b1; e.addr = 32'h1A10_8000; e.wdata = reg_wdata_i; e.chk_bus = 1'b1;
        exp_q.push_back(e);
        tick();
        e.pen = 1'b1;
        exp_q.push_back(e);
        tick();
        exp_q.push_back(e);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        reg_valid_i = 1'b0;
        e = '0;
        e.chk_all = 1'b1;
        exp_q.push_back(e);
        tick();
        start = cyc;
        apply_stimulus(32'h1A10_9000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'h7777_1111);
        check_output("t6_latency", 32'(rdy_cyc - start), 32'd3);

        for (int i = 0; i < 150; i++) begin
            ws = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            apply_stimulus($urandom, 1'($urandom), $urandom, ws, int'($urandom_range(0, 9)),
                           ($urandom_range(0, 3) == 0), $urandom);
            idle(int'($urandom_range(0, 2)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
